// File: rtl/fifo_chk_pkg.sv
// fifo_chk_pkg: shared types and helpers for the FIFO read-side checker.
// Contents: chk_err_e mismatch kinds, chk_state_e checker FSM states,
// sat_inc32 saturating counter increment.
package fifo_chk_pkg;
    typedef enum logic [2:0] {ERR_NONE, ERR_DATA, ERR_ACK, ERR_OVF, ERR_UDF, ERR_FLAG} chk_err_e;
    typedef enum logic [1:0] {IDLE, ARM, CHECK, HALT} chk_state_e;
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/fifo_chk_mirror.sv
// fifo_chk_mirror: shadow copy of the monitored FIFO storage and occupancy.
// Ports: clk, rst_n (async active-low), dut_rst_n (sampled DUT reset),
// wr_en/rd_en/data_in (monitored requests), cnt (mirror occupancy),
// rd_data (word at read pointer), wr_ok/rd_ok (requests that take effect).
module fifo_chk_mirror
    import fifo_chk_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          dut_rst_n,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    output logic [$clog2(FIFO_DEPTH):0]   cnt,
    output logic [FIFO_WIDTH-1:0]         rd_data,
    output logic                          wr_ok,
    output logic                          rd_ok
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign wr_ok   = wr_en && (cnt != (AW+1)'(FIFO_DEPTH));
    assign rd_ok   = rd_en && (cnt != '0);
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (!dut_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_ok);
            rd_ptr <= rd_ptr + AW'(rd_ok);
            cnt    <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (dut_rst_n && wr_ok) mem[wr_ptr] <= data_in;
    end
endmodule

// File: rtl/fifo_checker.sv
// fifo_checker: passive read-side checker for the synchronous FIFO.
// Ports: clk, rst_n (async active-low), dut_rst_n, data_in, wr_en, rd_en,
// data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty
// (all monitored); correct_count, error_count, err_pulse, err_kind, halted.
// Macro FIFO_FLAG_CHECK_EN: also check the combinational flags against the mirror.
module fifo_checker
    import fifo_chk_pkg::*;
#(
    parameter int FIFO_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter bit STOP_ON_ERR = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dut_rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  wr_ack,
    input  logic                  overflow,
    input  logic                  underflow,
    input  logic                  full,
    input  logic                  empty,
    input  logic                  almostfull,
    input  logic                  almostempty,
    output logic [31:0]           correct_count,
    output logic [31:0]           error_count,
    output logic                  err_pulse,
    output logic [2:0]            err_kind,
    output logic                  halted
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [AW:0] cnt;
    logic [FIFO_WIDTH-1:0] rd_data, exp_data;
    logic wr_ok, rd_ok, exp_ack, exp_ovf, exp_udf, flag_bad, chk, mis;
    chk_state_e state;
    chk_err_e kind;
    fifo_chk_mirror #(.FIFO_WIDTH(FIFO_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_mirror (
        .clk(clk), .rst_n(rst_n), .dut_rst_n(dut_rst_n), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .cnt(cnt), .rd_data(rd_data), .wr_ok(wr_ok), .rd_ok(rd_ok)
    );
`ifdef FIFO_FLAG_CHECK_EN
    assign flag_bad = (full != (cnt == (AW+1)'(FIFO_DEPTH))) || (empty != (cnt == '0)) ||
                      (almostfull != (cnt == (AW+1)'(FIFO_DEPTH-1))) || (almostempty != (cnt == (AW+1)'(1)));
`else
    logic unused_flags;
    assign unused_flags = ^{full, empty, almostfull, almostempty, cnt};
    assign flag_bad = 1'b0;
`endif
    // priority DATA > ACK > OVF > UDF > FLAG; at most one mismatch per cycle
    always_comb begin
        kind = (data_out != exp_data) ? ERR_DATA :
               (wr_ack != exp_ack)    ? ERR_ACK  :
               (overflow != exp_ovf)  ? ERR_OVF  :
               (underflow != exp_udf) ? ERR_UDF  :
               flag_bad               ? ERR_FLAG : ERR_NONE;
        chk  = state == CHECK;
        mis  = chk && (kind != ERR_NONE);
    end
    assign halted = state == HALT;
    // expectations for the DUT's registered outputs one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_data <= '0;
            exp_ack  <= 1'b0;
            exp_ovf  <= 1'b0;
            exp_udf  <= 1'b0;
        end else if (!dut_rst_n) begin
            exp_data <= '0;
            exp_ack  <= 1'b0;
            exp_ovf  <= 1'b0;
            exp_udf  <= 1'b0;
        end else begin
            exp_ack  <= wr_ok;
            exp_ovf  <= wr_en && !wr_ok;
            exp_udf  <= rd_en && !rd_ok;
            if (rd_ok) exp_data <= rd_data;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            correct_count <= '0;
            error_count   <= '0;
            err_pulse     <= 1'b0;
            err_kind      <= ERR_NONE;
        end else begin
            if (state != HALT && !dut_rst_n) state <= IDLE;
            else if (state == IDLE) state <= ARM;
            else if (state == ARM) state <= CHECK;
            else if (mis && STOP_ON_ERR) state <= HALT;
            err_pulse <= mis;
            if (mis) begin
                error_count <= sat_inc32(error_count);
                err_kind    <= kind;
            end else if (chk) begin
                correct_count <= sat_inc32(correct_count);
            end
        end
    end
endmodule
